// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: bus between the multicycle control FSM and its datapath/memory
// master (controller): takes instruction, ALUZero, memReady; drives strobes, selects and trap status.
// slave (datapath): the mirror image.
interface multicycle_controller_if;
  logic [31:0] instruction;
  logic        ALUZero;
  logic        memReady;
  logic        irWr, pcWr, memRd, memWr, regWr;
  logic [3:0]  ALUCtrl;
  logic        ALUImm, ALUToPC, branch, memToReg, rs2ShiftSel, uext, iFetch, trap;
  logic [1:0]  loadSel, maskSel, regDataSel, trapCause;
  modport master (
    input  instruction, ALUZero, memReady,
    output irWr, pcWr, memRd, memWr, regWr, ALUCtrl, ALUImm, ALUToPC, branch, memToReg,
           rs2ShiftSel, uext, iFetch, trap, loadSel, maskSel, regDataSel, trapCause
  );
  modport slave (
    output instruction, ALUZero, memReady,
    input  irWr, pcWr, memRd, memWr, regWr, ALUCtrl, ALUImm, ALUToPC, branch, memToReg,
           rs2ShiftSel, uext, iFetch, trap, loadSel, maskSel, regDataSel, trapCause
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32 multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory-wait timeout
// Ports: clk; rst_n (async, active-low); bus (multicycle_controller_if.master).
// Params: MEM_TIMEOUT (wait cycles tolerated per access), CNT_W (wait counter width).
// Macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap with cause 01 instead of retiring as a NOP.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                         ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP = 1'b1;
`else
  localparam bit ILL_TRAP = 1'b0;
`endif
  logic [2:0] state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] cause;
  logic [4:0] op;
  logic [2:0] f3;
  logic f7b;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_fence, is_sys;
  logic known, pc_only, in_f, wait_st, timeout, ill, dec_on, ls;
  logic [3:0] alu_f3, alu_ctrl;
  logic unused_bits;
  assign op = bus.instruction[6:2];
  assign f3 = bus.instruction[14:12];
  assign f7b = bus.instruction[30];
  assign unused_bits = ^{bus.instruction[31], bus.instruction[29:15], bus.instruction[11:7], bus.instruction[1:0]};
  assign is_r = op == 5'b01100;
  assign is_i = op == 5'b00100;
  assign is_ld = op == 5'b00000;
  assign is_st = op == 5'b01000;
  assign is_br = op == 5'b11000;
  assign is_jal = op == 5'b11011;
  assign is_jalr = op == 5'b11001;
  assign is_lui = op == 5'b01101;
  assign is_auipc = op == 5'b00101;
  assign is_fence = op == 5'b00011;
  assign is_sys = op == 5'b11100;
  assign known = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc | is_fence | is_sys;
  assign pc_only = is_br | is_fence | is_sys;
  // Gating FETCH with rst_n drops the fetch request combinationally while reset is held.
  assign in_f = rst_n && state == FETCH;
  assign wait_st = in_f || state == MEM;
  // memReady in the final allowed cycle still completes: timeout only fires without it.
  assign timeout = wait_st && !bus.memReady && cnt == CNT_W'(MEM_TIMEOUT);
  assign ill = state == DECODE && !known;
  assign nxt = state == FETCH  ? (bus.memReady ? DECODE : timeout ? TRAP : FETCH)
             : state == DECODE ? (known ? EXEC : ILL_TRAP ? TRAP : FETCH)
             : state == EXEC   ? (is_ld || is_st ? MEM : pc_only ? FETCH : WB)
             : state == MEM    ? (bus.memReady ? (is_ld ? WB : FETCH) : timeout ? TRAP : MEM)
             : state == TRAP   ? TRAP : FETCH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      cnt <= '0;
      cause <= 2'b00;
    end else begin
      state <= nxt;
      cnt <= wait_st && !bus.memReady && !timeout ? cnt + CNT_W'(1) : '0;
      cause <= timeout ? 2'b10 : ILL_TRAP && ill ? 2'b01 : cause;
    end
  assign alu_f3 = f3 == 3'd0 ? (is_r && f7b ? ALU_SUB : ALU_ADD)
                : f3 == 3'd1 ? ALU_SLL
                : f3 == 3'd2 ? ALU_SLT
                : f3 == 3'd3 ? ALU_SLTU
                : f3 == 3'd4 ? ALU_XOR
                : f3 == 3'd5 ? (f7b ? ALU_SRA : ALU_SRL)
                : f3 == 3'd6 ? ALU_OR : ALU_AND;
  assign alu_ctrl = is_r || is_i ? alu_f3
                  : is_br ? (f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB) : ALU_ADD;
  // Decoded selects are held steady for the whole instruction once the IR is loaded.
  assign dec_on = state inside {DECODE, EXEC, MEM, WB};
  assign ls = dec_on && (is_ld || is_st);
  assign bus.memRd = in_f || state == MEM && is_ld;
  assign bus.memWr = state == MEM && is_st;
  assign bus.iFetch = in_f;
  assign bus.irWr = in_f && bus.memReady;
  assign bus.pcWr = ill && !ILL_TRAP || state == EXEC && pc_only || state == MEM && is_st && bus.memReady || state == WB;
  assign bus.regWr = state == WB;
  // funct3[0]^funct3[2] is set for BNE/BLT/BLTU, which take the branch when the ALU result is nonzero.
  assign bus.branch = state == EXEC && is_br && (bus.ALUZero ^ f3[0] ^ f3[2]) || state == WB && (is_jal || is_jalr);
  assign bus.memToReg = state == WB && is_ld;
  assign bus.ALUCtrl = dec_on ? alu_ctrl : ALU_ADD;
  assign bus.ALUImm = dec_on && (is_i || is_ld || is_st || is_jalr);
  assign bus.ALUToPC = dec_on && is_jalr;
  assign bus.loadSel = ls ? f3[1:0] : 2'b00;
  assign bus.maskSel = ls ? f3[1:0] : 2'b00;
  assign bus.uext = ls && f3[2];
  assign bus.rs2ShiftSel = ls && f3[0];
  assign bus.regDataSel = !dec_on ? 2'b00 : is_jal || is_jalr ? 2'b11 : is_auipc ? 2'b10 : is_lui ? 2'b01 : 2'b00;
  assign bus.trap = state == TRAP;
  assign bus.trapCause = cause;
endmodule
